mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine. Consumes the EX/MEM register outputs (access flags, width, sign, ALU address, rt store data).
//  Runs a req/ack transaction on the data-memory/IO bus, stalling the pipeline until the transaction completes.
//  Returns aligned, sign/zero-extended load data to the MEM/WB register and flags address and bus errors to the CP0 exception logic.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in BUS without bus_ack before a bus error is raised
//  CNT_W           8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock      in   1   system clock, posedge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  flush      in   1   exception flush from WB; kills an access not yet on the bus
//  mem_read   in   1   load from data memory
//  mem_write  in   1   store to data memory
//  io_read    in   1   load from IO space
//  io_write   in   1   store to IO space
//  mem_sign   in   1   1 = sign-extend loads, 0 = zero-extend
//  mem_width  in   2   00 byte, 01 half, 11 word; 10 reserved, treated as word
//  addr       in   32  effective address (ALU result)
//  wdata      in   32  store data (rt value)
//  bus_req    out  1   transaction request, held until ack or timeout
//  bus_we     out  1   1 = write
//  bus_io     out  1   1 = IO space, 0 = memory
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_be     out  4   byte enables, little-endian lanes
//  bus_wdata  out  32  lane-replicated store data
//  bus_rdata  in   32  read data, valid when bus_ack=1
//  bus_ack    in   1   transaction complete
//  mem_stall  out  1   freeze IF..EX/MEM while 1
//  load_data  out  32  extended load result
//  load_valid out  1   one-cycle pulse; load_data is valid
//  adel       out  1   one-cycle pulse: misaligned load
//  ades       out  1   one-cycle pulse: misaligned store
//  bus_err    out  1   one-cycle pulse: ack timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0. Reset is asynchronous and may abort any state.
//  An access is requested when any of the four access flags is 1. A write flag takes priority over a read flag.
//  An IO flag takes priority over a memory flag.
//  Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
//  FSM IDLE -> BUS -> DONE -> IDLE.
//   IDLE: on an access with flush=0:
//    - Misaligned: pulse adel or ades on the next cycle; no bus_req; no stall; stay IDLE.
//    - Aligned: register addr, be, wdata, we and io; go to BUS.
//    - mem_stall is 1 combinationally in this cycle.
//   IDLE: on an access with flush=1: no transaction and no flag pulse.
//   BUS: bus_req=1 and mem_stall=1; all bus outputs stay stable; counter increments.
//    - On bus_ack: capture bus_rdata and go to DONE.
//    - If the counter reaches TIMEOUT_CYCLES with no ack: drop bus_req, pulse bus_err, go to IDLE.
//   DONE: mem_stall=0. For a read, load_valid=1 for this cycle. Go to IDLE unconditionally; the current inputs are not re-sampled.
//  flush in BUS is ignored; the transaction completes, but load_valid is suppressed.
//  bus_ack while in IDLE or DONE is ignored.
//  Minimum load latency: request in cycle 0, bus_req in cycle 1 with ack in the same cycle, load_valid in cycle 2.
//  bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//  bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  load_data: lane selected by addr[1:0], then extended per mem_sign; word loads pass through unchanged.
// STRUCTURE
//  Shared package minisys_mem_pkg holds:
//   - WIDTH_BYTE/HALF/WORD encodings
//   - state encodings IDLE/BUS/DONE
//   - byte-enable lookup function
//  Sub-module load_align (combinational): (rdata, addr[1:0], width, sign) -> load_data.
//  It is reused by the future IO read path.
// TESTING
//  1. lw addr=0x100, ack in the first BUS cycle, rdata=0xDEADBEEF -> be=1111, load_data=0xDEADBEEF, load_valid at cycle 2, stall for cycles 0-1.
//  2. lb sign=1 addr=0x103, rdata=0x80FF_FFFF -> be=1000, load_data=0xFFFFFF80.
//     Same access with sign=0 -> 0x00000080.
//  3. sh addr=0x202, wdata=0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, load_valid stays 0.
//  4. lw addr=0x101 -> adel pulses once, bus_req never asserts, mem_stall=0.
//     sw addr=0x102 -> ades pulses once.
//  5. Load with ack withheld, TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles, bus_err pulses once, FSM returns to IDLE.
//  6. reset driven to 0 mid-BUS -> all outputs 0 immediately; after release, a new sb completes normally.

Source files
------------

// File: rtl/minisys_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: width encodings,
// FSM state encodings and the byte-lane helper functions.
package minisys_mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Little-endian byte enables; the reserved width 2'b10 behaves as a word.
    function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (width)
            WIDTH_BYTE: be = 4'b0001 << addr_lo;
            WIDTH_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Half needs 2-byte alignment, word (and reserved) needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_HALF: mis = addr_lo[0];
            default:    mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    // Store data is replicated across lanes so the byte enables pick the right one.
    function automatic logic [31:0] lane_replicate(input logic [1:0] width, input logic [31:0] wdata);
        logic [31:0] rep;
        case (width)
            WIDTH_BYTE: rep = {4{wdata[7:0]}};
            WIDTH_HALF: rep = {2{wdata[15:0]}};
            default:    rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory / IO bus: req/ack handshake plus address, lanes and data.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic        bus_io;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_align.sv
// Selects the addressed lane of a 32-bit read word and sign/zero-extends it.
// Purely combinational so the IO read path can share it.
module load_align
    import minisys_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_width,
    input  logic        i_sign,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension; words pass straight through.
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_width)
            WIDTH_BYTE: o_load_data = {{24{i_sign & w_byte[7]}}, w_byte};
            WIDTH_HALF: o_load_data = {{16{i_sign & w_half[15]}}, w_half};
            default:    o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM access flags into one req/ack
// bus transaction, stalls the pipeline meanwhile, returns extended load
// data and reports misalignment and ack-timeout errors.
module mem_access_unit
    import minisys_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               io_read,
    input  logic               io_write,
    input  logic               mem_sign,
    input  logic [1:0]         mem_width,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    mem_access_unit_if.master  bus,
    output logic               mem_stall,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               adel,
    output logic               ades,
    output logic               bus_err
);

    // Last counter value of the BUS window; leaving on it gives exactly
    // TIMEOUT_CYCLES cycles of bus_req.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic             r_io;
    logic [31:2]      r_addr_hi;
    logic [1:0]       r_addr_lo;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_width;
    logic             r_sign;
    logic             r_flushed;
    logic [31:0]      r_load_data;
    logic             r_load_valid;
    logic             r_adel;
    logic             r_ades;
    logic             r_bus_err;

    logic             w_access;
    logic             w_we;
    logic             w_io;
    logic             w_misaligned;
    logic [31:0]      w_align_data;

    // Decode the request: write beats read, IO beats memory.
    always_comb begin
        w_access     = mem_read | mem_write | io_read | io_write;
        w_we         = mem_write | io_write;
        w_io         = w_we ? io_write : io_read;
        w_misaligned = is_misaligned(mem_width, addr[1:0]);
    end

    load_align u_load_align (
        .i_rdata     (bus.bus_rdata),
        .i_addr_lo   (r_addr_lo),
        .i_width     (r_width),
        .i_sign      (r_sign),
        .o_load_data (w_align_data)
    );

    // Transaction FSM with registered bus, result and error-pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_io         <= 1'b0;
            r_addr_hi    <= '0;
            r_addr_lo    <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_width      <= '0;
            r_sign       <= 1'b0;
            r_flushed    <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_adel       <= 1'b0;
            r_ades       <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_adel       <= 1'b0;
            r_ades       <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access && !flush) begin
                        if (w_misaligned) begin
                            r_adel <= ~w_we;
                            r_ades <= w_we;
                        end else begin
                            r_state   <= BUS;
                            r_req     <= 1'b1;
                            r_we      <= w_we;
                            r_io      <= w_io;
                            r_addr_hi <= addr[31:2];
                            r_addr_lo <= addr[1:0];
                            r_be      <= byte_enable(mem_width, addr[1:0]);
                            r_wdata   <= lane_replicate(mem_width, wdata);
                            r_width   <= mem_width;
                            r_sign    <= mem_sign;
                            r_cnt     <= '0;
                            r_flushed <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    // A flush cannot cancel a live transaction, only its result.
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (bus.bus_ack) begin
                        r_req        <= 1'b0;
                        r_state      <= DONE;
                        r_load_data  <= w_align_data;
                        r_load_valid <= ~r_we & ~r_flushed & ~flush;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall is raised in the request cycle itself so EX/MEM holds the access.
    always_comb begin
        mem_stall = reset &&
                    (((r_state == IDLE) && w_access && !flush && !w_misaligned) ||
                     (r_state == BUS));
    end

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_io    = r_io;
    assign bus.bus_addr  = {r_addr_hi, 2'b00};
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;
    assign load_data     = r_load_data;
    assign load_valid    = r_load_valid;
    assign adel          = r_adel;
    assign ades          = r_ades;
    assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with scoreboards for bus requests and
// load results.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic        io_read;
    logic        io_write;
    logic        mem_sign;
    logic [1:0]  mem_width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        adel;
    logic        ades;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic        io;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    bus_exp_t    bus_cur;
    logic [31:0] load_q[$];
    logic        prev_req;

    mem_access_unit_if bus_if();

    mem_access_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .io_read    (io_read),
        .io_write   (io_write),
        .mem_sign   (mem_sign),
        .mem_width  (mem_width),
        .addr       (addr),
        .wdata      (wdata),
        .bus        (bus_if.master),
        .mem_stall  (mem_stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .adel       (adel),
        .ades       (ades),
        .bus_err    (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    // Bus scoreboard: each new request is matched to the next expected one,
    // and bus fields must stay stable while the request is held.
    always @(negedge clock) begin
        if (bus_if.bus_req && !prev_req) begin
            check("bus_req_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
                bus_cur = bus_q.pop_front();
                check("bus_we", 32'(bus_if.bus_we), 32'(bus_cur.we));
                check("bus_io", 32'(bus_if.bus_io), 32'(bus_cur.io));
                check("bus_addr", bus_if.bus_addr, bus_cur.addr);
                check("bus_be", 32'(bus_if.bus_be), 32'(bus_cur.be));
                if (bus_cur.chk_wdata) begin
                    check("bus_wdata", bus_if.bus_wdata, bus_cur.wdata);
                end
            end
        end else if (bus_if.bus_req && prev_req) begin
            check("bus_addr_stable", bus_if.bus_addr, bus_cur.addr);
            check("bus_be_stable", 32'(bus_if.bus_be), 32'(bus_cur.be));
        end
        prev_req = bus_if.bus_req;
    end

    // Load scoreboard: every load_valid pulse consumes one expected result.
    always @(negedge clock) begin
        if (load_valid) begin
            check("load_expected", 32'(load_q.size() != 0), 32'd1);
            if (load_q.size() != 0) begin
                check("load_data", load_data, load_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [3:0] flags, input logic sign, input logic [1:0] width,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read  = flags[0];
        mem_write = flags[1];
        io_read   = flags[2];
        io_write  = flags[3];
        mem_sign  = sign;
        mem_width = width;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic push_bus(input logic we, input logic io, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        bus_exp_t e;
        e.we        = we;
        e.io        = io;
        e.addr      = {a[31:2], 2'b00};
        e.be        = be;
        e.wdata     = wd;
        e.chk_wdata = we;
        bus_q.push_back(e);
    endtask

    // One transaction acked in its first BUS cycle (minimum latency).
    task automatic run_txn(input logic [3:0] flags, input logic sign, input logic [1:0] width,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [31:0] exp_ld, input logic exp_we, input logic exp_io,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(posedge clock); #1;
        drive(flags, sign, width, a, wd);
        push_bus(exp_we, exp_io, a, exp_be, exp_wd);
        if (!exp_we) load_q.push_back(exp_ld);
        @(negedge clock);
        check("stall_c0", 32'(mem_stall), 32'd1);
        @(posedge clock); #1;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rd;
        @(negedge clock);
        check("req_c1", 32'(bus_if.bus_req), 32'd1);
        check("stall_c1", 32'(mem_stall), 32'd1);
        @(posedge clock); #1;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        @(negedge clock);
        check("load_valid_c2", 32'(load_valid), 32'(!exp_we));
        check("stall_c2", 32'(mem_stall), 32'd0);
    endtask

    // An access that must never reach the bus (misaligned or flushed).
    task automatic run_noissue(input logic [3:0] flags, input logic [1:0] width, input logic [31:0] a,
                               input logic fl, input logic exp_adel, input logic exp_ades);
        @(posedge clock); #1;
        drive(flags, 1'b0, width, a, 32'h1234_5678);
        flush = fl;
        @(negedge clock);
        check("noissue_stall", 32'(mem_stall), 32'd0);
        @(posedge clock); #1;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);
        flush = 1'b0;
        @(negedge clock);
        check("noissue_adel", 32'(adel), 32'(exp_adel));
        check("noissue_ades", 32'(ades), 32'(exp_ades));
        check("noissue_req", 32'(bus_if.bus_req), 32'd0);
        check("noissue_stall2", 32'(mem_stall), 32'd0);
        @(negedge clock);
        check("noissue_adel_once", 32'(adel), 32'd0);
        check("noissue_ades_once", 32'(ades), 32'd0);
        check("noissue_req2", 32'(bus_if.bus_req), 32'd0);
    endtask

    initial begin
        int n_req;
        int n_berr;
        reset     = 1'b0;
        flush     = 1'b0;
        prev_req  = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);

        // Reset state
        @(negedge clock);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_errs", {29'd0, adel, ades, bus_err}, 32'd0);
        check("rst_addr", bus_if.bus_addr, 32'd0);
        check("rst_be", 32'(bus_if.bus_be), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Loads: word, signed/unsigned byte, half, IO, reserved width
        run_txn(4'b0001, 1'b0, 2'b11, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0);
        run_txn(4'b0001, 1'b1, 2'b00, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1000, 32'h0);
        run_txn(4'b0001, 1'b0, 2'b00, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 32'h0000_0080, 1'b0, 1'b0, 4'b1000, 32'h0);
        run_txn(4'b0001, 1'b1, 2'b01, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 1'b0, 4'b1100, 32'h0);
        run_txn(4'b0001, 1'b1, 2'b01, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0, 1'b0, 4'b0011, 32'h0);
        run_txn(4'b0101, 1'b0, 2'b11, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1111, 32'h0);
        run_txn(4'b0001, 1'b1, 2'b10, 32'h0000_0104, 32'h0, 32'h8765_4321, 32'h8765_4321, 1'b0, 1'b0, 4'b1111, 32'h0);

        // Stores: half, IO word, byte with read flag also set
        run_txn(4'b0010, 1'b0, 2'b01, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 32'h0, 1'b1, 1'b0, 4'b1100, 32'hABCD_ABCD);
        run_txn(4'b1000, 1'b0, 2'b11, 32'h0000_0020, 32'h55AA_1234, 32'h0, 32'h0, 1'b1, 1'b1, 4'b1111, 32'h55AA_1234);
        run_txn(4'b0011, 1'b0, 2'b00, 32'h0000_0301, 32'h0000_00C3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0010, 32'hC3C3_C3C3);

        // Misaligned accesses and flushed requests
        run_noissue(4'b0001, 2'b11, 32'h0000_0101, 1'b0, 1'b1, 1'b0);
        run_noissue(4'b0010, 2'b11, 32'h0000_0102, 1'b0, 1'b0, 1'b1);
        run_noissue(4'b0010, 2'b01, 32'h0000_0103, 1'b0, 1'b0, 1'b1);
        run_noissue(4'b0001, 2'b11, 32'h0000_0600, 1'b1, 1'b0, 1'b0);
        run_noissue(4'b0001, 2'b11, 32'h0000_0601, 1'b1, 1'b0, 1'b0);

        // Ack timeout: four request cycles, one bus_err pulse, back to IDLE
        @(posedge clock); #1;
        drive(4'b0001, 1'b0, 2'b11, 32'h0000_0300, 32'h0);
        push_bus(1'b0, 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
        @(posedge clock); #1;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);
        n_req  = 0;
        n_berr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus_if.bus_req) n_req++;
            if (bus_err) n_berr++;
        end
        check("timeout_req_cycles", 32'(n_req), 32'd4);
        check("timeout_bus_err_pulses", 32'(n_berr), 32'd1);
        check("timeout_idle_stall", 32'(mem_stall), 32'd0);

        // Ack while idle is ignored
        @(posedge clock); #1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("idle_ack_req", 32'(bus_if.bus_req), 32'd0);
        @(posedge clock); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clock);
        check("idle_ack_load_valid", 32'(load_valid), 32'd0);
        check("idle_ack_stall", 32'(mem_stall), 32'd0);

        // Flush during BUS: transaction completes, load result suppressed
        @(posedge clock); #1;
        drive(4'b0001, 1'b0, 2'b11, 32'h0000_0500, 32'h0);
        push_bus(1'b0, 1'b0, 32'h0000_0500, 4'b1111, 32'h0);
        @(posedge clock); #1;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clock);
        check("flush_bus_req", 32'(bus_if.bus_req), 32'd1);
        @(posedge clock); #1;
        flush = 1'b0;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1111_1111;
        @(negedge clock);
        check("flush_bus_req2", 32'(bus_if.bus_req), 32'd1);
        @(posedge clock); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clock);
        check("flush_load_valid", 32'(load_valid), 32'd0);
        check("flush_stall", 32'(mem_stall), 32'd0);

        // Asynchronous reset in the middle of BUS
        @(posedge clock); #1;
        drive(4'b0001, 1'b0, 2'b11, 32'h0000_0400, 32'h0);
        push_bus(1'b0, 1'b0, 32'h0000_0400, 4'b1111, 32'h0);
        @(posedge clock); #1;
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clock);
        check("midbus_req", 32'(bus_if.bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", 32'(bus_if.bus_req), 32'd0);
        check("arst_stall", 32'(mem_stall), 32'd0);
        check("arst_addr", bus_if.bus_addr, 32'd0);
        check("arst_be", 32'(bus_if.bus_be), 32'd0);
        check("arst_load_data", load_data, 32'd0);
        @(posedge clock); #3;
        reset = 1'b1;

        // Store byte after reset completes normally
        run_txn(4'b0010, 1'b0, 2'b00, 32'h0000_0405, 32'h0000_00A5, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0010, 32'hA5A5_A5A5);

        @(negedge clock);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("load_q_drained", 32'(load_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
